// File: rtl/tile_row_shifter.sv
// Tile-row pixel serialiser: queues planar rows, emits one {palette, pixel} per ce_pix
// with fine scroll, horizontal flip and underflow reporting.

// One output pixel gathered across all bitplanes, with flip resolved.
module tile_row_pix #(
  parameter int BPP     = 4,
  parameter int ROW_PIX = 8,
  parameter int IDX     = 0
) (
  input  logic [BPP*ROW_PIX-1:0] row,
  input  logic                   reverse,
  output logic [BPP-1:0]         pix
);
  for (genvar p = 0; p < BPP; p++) begin : g_plane
    assign pix[p] = reverse ? row[(BPP-1-p)*ROW_PIX + IDX] : row[(BPP-p)*ROW_PIX - 1 - IDX];
  end
endmodule

module tile_row_shifter #(
  parameter int BPP     = 4,
  parameter int ROW_PIX = 8,
  parameter int PAL_W   = 7,
  parameter int PRIO_W  = 2,
  parameter int QDEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce_pix,
  input  logic                       line_start,
  input  logic [$clog2(ROW_PIX)-1:0] offset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BPP*ROW_PIX-1:0]     row,
  input  logic                       reverse,
  input  logic [PAL_W-1:0]           palette,
  input  logic [PRIO_W-1:0]          prio,
  output logic [PAL_W+BPP-1:0]       color_out,
  output logic [PRIO_W-1:0]          prio_out,
  output logic                       opaque_out,
  output logic                       underflow
);
  localparam int CW = $clog2(ROW_PIX);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int OW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [ROW_PIX-1:0][BPP-1:0] px;
    logic [PAL_W-1:0]            pal;
    logic [PRIO_W-1:0]           prio;
  } row_ent_t;

  logic [ROW_PIX-1:0][BPP-1:0] px_in;
  row_ent_t                    ent_in;
  row_ent_t                    q_mem [QDEPTH];
  logic [PW-1:0]               wptr, rptr;
  logic [OW-1:0]               occ;
  logic [CW-1:0]               cnt, pos;
  logic [ROW_PIX-1:0][BPP-1:0] pix_cur;
  logic [PAL_W-1:0]            pal_cur;
  logic [PRIO_W-1:0]           prio_cur;
  logic                        full, empty, bnd, push, pop;

  // Pixel 0 lands in the low BPP bits so a plain right shift walks the row.
  for (genvar i = 0; i < ROW_PIX; i++) begin : g_pix
    tile_row_pix #(.BPP(BPP), .ROW_PIX(ROW_PIX), .IDX(i)) u_pix (
      .row(row), .reverse(reverse), .pix(px_in[i])
    );
  end

  assign ent_in = '{px: px_in, pal: palette, prio: prio};

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (occ == OW'(QDEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign pos      = cnt + offset;
  assign bnd      = ce_pix && (pos == CW'(ROW_PIX - 1));
  assign push     = in_valid && in_ready && !line_start;
  assign pop      = bnd && !empty && !line_start;

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) q_mem[wptr] <= ent_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      pix_cur   <= '0;
      pal_cur   <= '0;
      prio_cur  <= '0;
      underflow <= 1'b0;
    end else if (line_start) begin
      cnt       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      pix_cur   <= '0;
      pal_cur   <= '0;
      prio_cur  <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (push) wptr <= ptr_nxt(wptr);
      if (pop)  rptr <= ptr_nxt(rptr);
      occ <= occ + OW'(push) - OW'(pop);
      if (ce_pix) begin
        cnt <= cnt + CW'(1);
        if (bnd) begin
          if (!empty) begin
            pix_cur  <= q_mem[rptr].px;
            pal_cur  <= q_mem[rptr].pal;
            prio_cur <= q_mem[rptr].prio;
          end else begin
            pix_cur   <= '0;
            pal_cur   <= '0;
            prio_cur  <= '0;
            underflow <= 1'b1;
          end
        end else begin
          pix_cur <= pix_cur >> BPP;
        end
      end
    end
  end

  assign color_out  = {pal_cur, pix_cur[0]};
  assign prio_out   = prio_cur;
  assign opaque_out = |pix_cur[0];
endmodule

// File: tb/tb_tile_row_shifter.sv
// Bench for tile_row_shifter: queue-based row model checked every negedge,
// plus hand-computed expectations for the directed scenarios.
module tb_tile_row_shifter;
  localparam int BPP = 4, ROW_PIX = 8, PAL_W = 7, PRIO_W = 2, QDEPTH = 2;
  localparam int CW = $clog2(ROW_PIX);

  logic                   clk, reset_n, ce_pix, line_start, in_valid, in_ready, reverse;
  logic [CW-1:0]          offset;
  logic [BPP*ROW_PIX-1:0] row;
  logic [PAL_W-1:0]       palette;
  logic [PRIO_W-1:0]      prio;
  logic [PAL_W+BPP-1:0]   color_out;
  logic [PRIO_W-1:0]      prio_out;
  logic                   opaque_out, underflow;

  tile_row_shifter #(.BPP(BPP), .ROW_PIX(ROW_PIX), .PAL_W(PAL_W), .PRIO_W(PRIO_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .line_start(line_start), .offset(offset),
    .in_valid(in_valid), .in_ready(in_ready), .row(row), .reverse(reverse), .palette(palette),
    .prio(prio), .color_out(color_out), .prio_out(prio_out), .opaque_out(opaque_out),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROW_PIX-1:0][BPP-1:0] px;
    logic [PAL_W-1:0]            pal;
    logic [PRIO_W-1:0]           pr;
  } ent_t;

  ent_t m_q[$];
  ent_t m_cur;
  int   m_cnt, m_idx;
  bit   m_uf;
  bit   run;
  int   errors = 0, checks = 0;

  function automatic ent_t make_ent(logic [BPP*ROW_PIX-1:0] r, logic rev,
                                    logic [PAL_W-1:0] pal, logic [PRIO_W-1:0] pr);
    ent_t e;
    e.pal = pal;
    e.pr  = pr;
    for (int i = 0; i < ROW_PIX; i++)
      for (int p = 0; p < BPP; p++)
        e.px[i][p] = rev ? r[(BPP-1-p)*ROW_PIX + i] : r[(BPP-p)*ROW_PIX - 1 - i];
    return e;
  endfunction

  function automatic logic [BPP-1:0] m_pix();
    return (m_idx < ROW_PIX) ? m_cur.px[m_idx] : '0;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_cur = '0;
    m_cnt = 0;
    m_idx = 0;
    m_uf  = 0;
  endtask

  // Model reacts to the inputs present at the edge just taken.
  task automatic model_edge();
    bit acc;
    if (!reset_n || line_start) begin
      m_reset();
    end else begin
      acc  = in_valid && (m_q.size() < QDEPTH);
      m_uf = 0;
      if (ce_pix) begin
        if (((m_cnt + int'(offset)) % ROW_PIX) == ROW_PIX - 1) begin
          if (m_q.size() > 0) m_cur = m_q.pop_front();
          else begin m_cur = '0; m_uf = 1; end
          m_idx = 0;
        end else if (m_idx < ROW_PIX) begin
          m_idx++;
        end
        m_cnt = (m_cnt + 1) % ROW_PIX;
      end
      if (acc) m_q.push_back(make_ent(row, reverse, palette, prio));
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push_row(logic [31:0] r, logic rev, logic [PAL_W-1:0] pal, logic [PRIO_W-1:0] pr);
    in_valid = 1; row = r; reverse = rev; palette = pal; prio = pr;
    step();
    in_valid = 0;
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("m_color",  32'(color_out),  32'({m_cur.pal, m_pix()}));
      chk("m_prio",   32'(prio_out),   32'(m_cur.pr));
      chk("m_opaque", 32'(opaque_out), 32'(|m_pix()));
      chk("m_uflow",  32'(underflow),  32'(m_uf));
      chk("m_ready",  32'(in_ready),   32'(m_q.size() < QDEPTH));
    end
  end

  initial begin
    run = 0; reset_n = 0; ce_pix = 0; line_start = 0; offset = 7;
    in_valid = 0; row = '0; reverse = 0; palette = '0; prio = '0;
    m_reset();
    #12 reset_n = 1;
    #1;
    chk("rst_color", 32'(color_out), 0);
    chk("rst_prio",  32'(prio_out), 0);
    chk("rst_opq",   32'(opaque_out), 0);
    chk("rst_uf",    32'(underflow), 0);
    chk("rst_ready", 32'(in_ready), 1);
    run = 1;

    // order: one row of eight opaque pixels, then an underflow
    line_start = 1; step(); line_start = 0;
    offset = 7;
    push_row(32'hFF00_0000, 0, 7'h05, 2);
    ce_pix = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 8) begin
        chk("order_color", 32'(color_out), 32'h051);
        chk("order_prio",  32'(prio_out), 2);
        chk("order_opq",   32'(opaque_out), 1);
      end else if (k == 8) begin
        chk("order_ucolor", 32'(color_out), 0);
        chk("order_uf",     32'(underflow), 1);
      end else begin
        chk("order_uf_end", 32'(underflow), 0);
      end
    end

    // flip
    ce_pix = 0;
    line_start = 1; step(); line_start = 0;
    push_row(32'h8000_0000, 0, 7'h00, 1);
    push_row(32'h8000_0000, 1, 7'h00, 1);
    ce_pix = 1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) begin chk("flip_a0", 32'(color_out), 1); chk("flip_prio", 32'(prio_out), 1); end
      if (k == 1)  chk("flip_a1", 32'(color_out), 0);
      if (k == 8)  chk("flip_b0", 32'(color_out), 0);
      if (k == 15) chk("flip_b7", 32'(color_out), 1);
    end

    // fine scroll
    ce_pix = 0;
    line_start = 1; step(); line_start = 0;
    offset = 3;
    push_row(32'hF000_0000, 0, 7'h2A, 3);
    push_row(32'hFFFF_FFFF, 0, 7'h33, 1);
    ce_pix = 1;
    for (int k = 0; k < 13; k++) begin
      step();
      if (k == 3)  chk("scroll_pre",  32'(color_out), 0);
      if (k == 4)  begin chk("scroll_a0", 32'(color_out), 32'h2A1); chk("scroll_prio", 32'(prio_out), 3); end
      if (k == 11) chk("scroll_a7",   32'(color_out), 32'h2A0);
      if (k == 12) chk("scroll_b0",   32'(color_out), 32'h33F);
    end

    // backpressure
    ce_pix = 0;
    line_start = 1; step(); line_start = 0;
    offset = 7;
    push_row(32'hFFFF_FFFF, 0, 7'h11, 0);
    push_row(32'hFFFF_FFFF, 0, 7'h22, 1);
    chk("bp_full", 32'(in_ready), 0);
    in_valid = 1; palette = 7'h33; prio = 2;
    ce_pix = 1; step(); ce_pix = 0;
    chk("bp_popA",  32'(color_out), 32'h11F);
    chk("bp_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    chk("bp_refull", 32'(in_ready), 0);
    ce_pix = 1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 7)  chk("bp_B", 32'(color_out), 32'h22F);
      if (k == 15) chk("bp_C", 32'(color_out), 32'h33F);
    end

    // line_start mid-row with queued rows and a concurrent offer
    ce_pix = 0;
    line_start = 1; step(); line_start = 0;
    push_row(32'h1234_5678, 0, 7'h44, 1);
    push_row(32'h9ABC_DEF0, 1, 7'h55, 2);
    ce_pix = 1;
    repeat (3) step();
    line_start = 1; in_valid = 1; row = 32'hFFFF_FFFF;
    step();
    line_start = 0; in_valid = 0;
    chk("ls_ready", 32'(in_ready), 1);
    chk("ls_color", 32'(color_out), 0);
    chk("ls_uf",    32'(underflow), 0);
    step();
    chk("ls_empty_uf", 32'(underflow), 1);
    ce_pix = 0;

    // async reset mid-row
    line_start = 1; step(); line_start = 0;
    push_row(32'hFFFF_FFFF, 0, 7'h7F, 3);
    ce_pix = 1;
    step(); step();
    #2 reset_n = 0;
    m_reset();
    #1;
    chk("ar_color", 32'(color_out), 0);
    chk("ar_prio",  32'(prio_out), 0);
    chk("ar_opq",   32'(opaque_out), 0);
    chk("ar_ready", 32'(in_ready), 1);
    @(posedge clk);
    #3 reset_n = 1;
    step();
    chk("ar_uf", 32'(underflow), 1);
    ce_pix = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ce_pix     = ($urandom_range(0, 2) != 0);
      in_valid   = $urandom_range(0, 1);
      row        = $urandom;
      reverse    = $urandom_range(0, 1);
      palette    = PAL_W'($urandom);
      prio       = PRIO_W'($urandom);
      line_start = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) offset = CW'($urandom);
      step();
    end
    ce_pix = 0; in_valid = 0; line_start = 0;

    @(negedge clk);
    #1 run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_row_shifter.md
Name: tile_row_shifter

Overview:
Parametrised tile-row pixel serialiser for the GA23 tilemap path. It accepts planar tile rows through a valid/ready queue and emits one pixel per ce_pix. Each pixel carries palette, priority and an opaque flag. It supports configurable bit depth, row width, fine-scroll offset, horizontal flip and explicit underflow reporting. The block sits between the VRAM/ROM fetch sequencer and the layer mixer.

Parameters:
BPP, 4, bits per pixel (number of bitplanes), 1..8
ROW_PIX, 8, pixels per tile row, power of two, 4..16
PAL_W, 7, palette index width
PRIO_W, 2, priority width
QDEPTH, 2, row queue depth, 1..4

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce_pix  in  1  pixel clock enable
line_start  in  1  synchronous line restart; honoured on any clk
offset  in  $clog2(ROW_PIX)  fine horizontal scroll
in_valid  in  1  row offered
in_ready  out  1  queue can accept a row
row  in  BPP*ROW_PIX  planar row data
reverse  in  1  horizontal flip for the offered row
palette  in  PAL_W  palette for the offered row
prio  in  PRIO_W  priority for the offered row
color_out  out  PAL_W+BPP  {pal_cur, current pixel}
prio_out  out  PRIO_W  priority of the current row
opaque_out  out  1  current pixel != 0
underflow  out  1  one-clk pulse: row boundary reached with the queue empty

Behaviour:
- Reset (async, reset_n low):
  - cnt=0, queue empty, pix_cur=0, pal_cur=0, prio_cur=0, underflow=0.
  - Outputs therefore read color_out=0, prio_out=0, opaque_out=0, in_ready=1.
- Push:
  - Occurs on any clk with in_valid && in_ready; independent of ce_pix.
  - The row is stored already de-planarised and flip-resolved.
  - For pixel i (0 = leftmost) and plane p: bit p = reverse ? row[(BPP-1-p)*ROW_PIX + i] : row[(BPP-p)*ROW_PIX - 1 - i].
  - palette and prio are captured with the row.
- in_ready = !full, computed combinationally from the registered occupancy. A push in the same clk as a pop while full is refused.
- On ce_pix (when line_start is low):
  - cnt <= cnt+1, mod ROW_PIX.
  - Boundary when (cnt+offset) mod ROW_PIX == ROW_PIX-1.
  - At a boundary with the queue non-empty: pix_cur, pal_cur and prio_cur <= queue head; the head is popped.
  - At a boundary with the queue empty: pix_cur, pal_cur and prio_cur <= 0, and underflow pulses for that clk.
  - Otherwise pix_cur shifts right by BPP, zero-filled.
- Outputs: color_out = {pal_cur, pix_cur[BPP-1:0]}; opaque_out = |pix_cur[BPP-1:0]. Outputs are stable between ce_pix.
- Timing: a pixel becomes visible the clk after the ce_pix edge that loads or shifts it.
- line_start (priority over ce_pix and push in the same clk):
  - cnt=0, queue flushed, pix_cur, pal_cur and prio_cur = 0, no underflow pulse.
  - A concurrent in_valid is dropped; in_ready stays 1 that clk.
- Simultaneous push and pop when not full: both take effect; occupancy is unchanged.
- The queue is a circular buffer. Read and write pointers wrap mod QDEPTH; occupancy runs 0..QDEPTH.
- offset is sampled every ce_pix. Changing it mid-row moves the next boundary; no glitch protection is provided.

Test Plan:
- Reset/order (defaults): line_start, offset=7, push row=32'hFF00_0000, palette=7'h05, prio=2, reverse=0 -> after the next ce_pix, 8 pixels with color_out=11'h051, prio_out=2, opaque_out=1. The following boundary underflows: color_out=0, underflow pulses.
- Flip: push row=32'h8000_0000 with reverse=0 -> pixel0=1, pixels1-7=0. Same row with reverse=1 -> pixel7=1, pixels0-6=0.
- Fine scroll: line_start, offset=3, queue holds row A -> A loads on the 5th ce_pix (cnt=4). Subsequent loads every 8 ce_pix.
- Backpressure: with ce_pix low, push 2 rows -> in_ready=0; a held third row is accepted the clk after the next boundary pop. Rows then emerge in order A,B,C.
- line_start mid-row with 2 queued rows and in_valid high -> next clk: queue empty, in_ready=1, color_out=0, no underflow pulse.
- Async reset mid-row (reset_n low between clk edges) -> all outputs zero immediately. After release, in_ready=1 and the first boundary without a push underflows.
